// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, baud divider
// calculation and parity check.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RECOVER
    } rx_state_t;

    // Clocks per oversample tick; truncating division, never below 1.
    function automatic int calc_div(input int clk_freq_hz, input int baud_rate,
                                    input int oversample);
        int d;
        d = clk_freq_hz / (baud_rate * oversample);
        if (d < 1) d = 1;
        return d;
    endfunction

    // 1 when the received parity bit does not match the data (odd = 1 selects odd parity).
    function automatic logic parity_bad(input logic [7:0] data, input logic pbit,
                                        input logic odd);
        return (^data) ^ pbit ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider; one-cycle pulse every DIV clocks
// (high every cycle when DIV = 1). Shared by the UART receiver and transmitter.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: oversampled start qualification, LSB-first deserialiser,
// valid/ready output with framing/overrun flags. UART_RX_PARITY_EN adds a parity bit.
module uart_receiver #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    import uart_pkg::*;

    // state   | meaning
    // IDLE    | line idle, waiting for rx_s low
    // START   | checking start bit at its centre (glitch filter)
    // DATA    | sampling data bits at bit centres
    // PARITY  | sampling parity bit (UART_RX_PARITY_EN only)
    // STOP    | sampling stop bit; deliver or flag framing error
    // RECOVER | after bad stop bit, wait for line to return high

    localparam int             DIV    = calc_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int             TW     = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  T_END  = TW'(OVERSAMPLE - 1);
    localparam int             BW     = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  B_LAST = BW'(DATA_BITS - 1);

    logic                 rx_meta, rx_s;
    logic                 tick;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_ok, stop_bad;
    logic                 deliver;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic [7:0] data_ext;

    always_comb begin
        data_ext                  = '0;
        data_ext[DATA_BITS-1:0]   = shreg_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        shreg_d   = shreg_q;
        par_bad_d = par_bad_q;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tcnt_d  = '0;
                    end
                end
                START: begin
                    if (tcnt_q == T_MID) begin
                        tcnt_d    = '0;
                        bcnt_d    = '0;
                        par_bad_d = 1'b0;
                        state_d   = rx_s ? IDLE : DATA;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tcnt_q == T_END) begin
                        tcnt_d  = '0;
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bcnt_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tcnt_q == T_END) begin
                        tcnt_d    = '0;
                        par_bad_d = parity_bad(data_ext, rx_s, PARITY_ODD[0]);
                        state_d   = STOP;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tcnt_q == T_END) begin
                        tcnt_d = '0;
                        // Return to IDLE mid stop bit so the next start edge is caught early.
                        if (rx_s) begin
                            stop_ok = 1'b1;
                            state_d = IDLE;
                        end else begin
                            stop_bad = 1'b1;
                            state_d  = RECOVER;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                RECOVER: begin
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign deliver = stop_ok & ~par_bad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_bad;
`ifdef UART_RX_PARITY_EN
            parity_err <= (stop_ok | stop_bad) & par_bad_q;
`else
            parity_err <= 1'b0;
`endif
            overrun <= 1'b0;
            if (deliver) begin
                // Pending byte not being accepted: keep it and drop the new one.
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data  <= shreg_q;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at DIV=1, 16 clocks per bit; expected
// bytes go into a queue when a frame is sent and are compared on each accept.
module tb_uart_receiver;

    localparam int CLK_FREQ_HZ = 1_600_000;
    localparam int BAUD_RATE   = 100_000;
    localparam int OVERSAMPLE  = 16;
    localparam int DATA_BITS   = 8;
    localparam int PARITY_ODD  = 0;
    localparam int BIT_CLKS    = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, busy, frame_err, parity_err, overrun;

    always #5 clk = ~clk;

    uart_receiver #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD_RATE   (BAUD_RATE),
        .OVERSAMPLE  (OVERSAMPLE),
        .DATA_BITS   (DATA_BITS),
        .PARITY_ODD  (PARITY_ODD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_q[$];
    int   cyc = 0;
    int   valid_hi = 0, ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;
    int   valid_rise_cyc = -1;
    logic valid_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) valid_hi++;
        if (rx_valid && !valid_prev) valid_rise_cyc = cyc;
        valid_prev = rx_valid;
        if (frame_err)  ferr_cnt++;
        if (parity_err) perr_cnt++;
        if (overrun)    ovr_cnt++;
        if (rst_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) check_val("byte_pending", 32'(exp_q.size()), 32'd1);
            else                   check_val("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < DATA_BITS; i++) hold(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ PARITY_ODD[0] ^ par_flip, BIT_CLKS);
`endif
        hold(stop_v, BIT_CLKS);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain", 32'(exp_q.size()), 32'd0);
    endtask

    int v0, f0, p0, o0, s0, lat;
    logic [7:0] rnd;

    initial begin
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_val("rst_data",   {24'd0, rx_data}, 32'd0);
        check_val("rst_valid",  32'(rx_valid), 32'd0);
        check_val("rst_busy",   32'(busy), 32'd0);
        check_val("rst_ferr",   32'(frame_err), 32'd0);
        check_val("rst_perr",   32'(parity_err), 32'd0);
        check_val("rst_ovr",    32'(overrun), 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 5);

        // single byte, consumer always ready
        rx_ready = 1'b1;
        v0 = valid_hi;
        s0 = cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 10);
        check_val("a5_valid_cycles", 32'(valid_hi - v0), 32'd1);
        lat = valid_rise_cyc - s0;
        check_val("a5_latency_window", 32'(lat >= 150 && lat <= 160), 32'd1);
        wait_drain();

        // overrun: second byte completes while the first is still pending
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        hold(1'b1, 10);
        check_val("ovr_count", 32'(ovr_cnt - o0), 32'd1);
        check_val("ovr_valid_held", 32'(rx_valid), 32'd1);
        check_val("ovr_data_kept", {24'd0, rx_data}, 32'h3C);
        rx_ready = 1'b1;
        wait_drain();
        hold(1'b1, 3);
        check_val("ovr_valid_drop", 32'(rx_valid), 32'd0);

        // start-bit glitch
        v0 = valid_hi; f0 = ferr_cnt; o0 = ovr_cnt;
        hold(1'b0, 4);
        check_val("glitch_busy", 32'(busy), 32'd1);
        hold(1'b1, 30);
        check_val("glitch_idle", 32'(busy), 32'd0);
        check_val("glitch_valid", 32'(valid_hi - v0), 32'd0);
        check_val("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        check_val("glitch_ovr", 32'(ovr_cnt - o0), 32'd0);

        // bad stop bit followed by a break
        v0 = valid_hi; f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        hold(1'b0, 100);
        check_val("brk_ferr", 32'(ferr_cnt - f0), 32'd1);
        check_val("brk_busy", 32'(busy), 32'd1);
        check_val("brk_valid", 32'(valid_hi - v0), 32'd0);
        hold(1'b1, 5);
        check_val("brk_idle", 32'(busy), 32'd0);

        // reset in the middle of a 0xFF frame
        hold(1'b0, BIT_CLKS);
        hold(1'b1, 3 * BIT_CLKS);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_data",  {24'd0, rx_data}, 32'd0);
        check_val("mid_rst_valid", 32'(rx_valid), 32'd0);
        check_val("mid_rst_busy",  32'(busy), 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        hold(1'b1, 5);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        hold(1'b1, 10);
        wait_drain();

        // back-to-back random bytes
        for (int k = 0; k < 6; k++) begin
            rnd = 8'($urandom_range(0, 255));
            exp_q.push_back(rnd);
            send_frame(rnd, 1'b1);
        end
        hold(1'b1, 10);
        wait_drain();

`ifdef UART_RX_PARITY_EN
        v0 = valid_hi; p0 = perr_cnt;
        par_flip = 1'b1;
        send_frame(8'h01, 1'b1);
        hold(1'b1, 10);
        check_val("par_err_count", 32'(perr_cnt - p0), 32'd1);
        check_val("par_err_valid", 32'(valid_hi - v0), 32'd0);
        par_flip = 1'b0;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        hold(1'b1, 10);
        wait_drain();
        p0 = perr_cnt; f0 = ferr_cnt; v0 = valid_hi;
        par_flip = 1'b1;
        send_frame(8'h01, 1'b0);
        hold(1'b1, 10);
        par_flip = 1'b0;
        check_val("both_perr", 32'(perr_cnt - p0), 32'd1);
        check_val("both_ferr", 32'(ferr_cnt - f0), 32'd1);
        check_val("both_valid", 32'(valid_hi - v0), 32'd0);
`else
        p0 = perr_cnt;
        check_val("no_parity_err", 32'(p0), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
